nec_motor_ctrl: RTL and testbench

Parametrised multi-channel successor to the single-motor remote control path. It takes decoded 32-bit NEC frames (bit-reversed, as produced by the IR decoder) with a valid strobe. It maintains per-channel on/off, direction and target speed, and soft-ramps the applied duty. Each channel drives an H-bridge pair with glitch-free PWM and a braked, dead-timed direction reversal. It sits between the IR decoder and the motor driver pins, replacing the separate control and PWM stages.

---
 rtl/nec_motor_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_nec_motor_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/nec_motor_ctrl.sv
// nec_motor_ctrl: multi-channel NEC remote motor controller.
// Decodes NEC command frames, keeps per-channel on/off, direction and target
// duty, soft-ramps the applied duty and drives each H-bridge pair with PWM.
// Optional build macro: ADDR_FILTER_EN (also check address byte and its
// complement against ADDR_VAL).
//
// state   | meaning
// --------+---------------------------------------------------------------
// StOff   | channel idle, applied duty held at 0, pair outputs low
// StRun   | applied duty ramps toward target on each ramp tick
// StBrake | applied duty ramps to 0, then dead time, then dir flips -> StRun
module nec_motor_ctrl #(
  parameter int          CHANNELS   = 2,
  parameter int          DUTY_W     = 7,
  parameter int          PWM_PERIOD = 100,
  parameter int          PRESCALE   = 240,
  parameter int          DUTY_STEP  = 10,
  parameter int          DUTY_INIT  = 30,
  parameter int          RAMP_DIV   = 1000,
  parameter int          DEAD_CYC   = 2000,
  parameter logic [7:0]  KEY_PWR    = 8'h45,
  parameter logic [7:0]  KEY_UP     = 8'h46,
  parameter logic [7:0]  KEY_DN     = 8'h15,
  parameter logic [7:0]  KEY_DIR    = 8'h44,
  parameter logic [7:0]  KEY_CH     = 8'h40,
  parameter logic [7:0]  ADDR_VAL   = 8'h00
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CodeValid,
  input  logic [31:0]           CodeIn,
  output logic [2*CHANNELS-1:0] DriveOut,
  output logic [2:0]            SelChan,
  output logic [CHANNELS-1:0]   ChanOn,
  output logic                  CodeErr
);

  localparam int RAMP_W = $clog2(RAMP_DIV + 1);
  localparam int PRE_W  = $clog2(PRESCALE + 1);
  localparam int DEAD_W = $clog2(DEAD_CYC + 1);
  // A step larger than the period saturates identically to a step of one period.
  localparam int STEP_SAT = (DUTY_STEP > PWM_PERIOD) ? PWM_PERIOD : DUTY_STEP;

  localparam logic [DUTY_W:0]   STEP_X    = (DUTY_W+1)'(STEP_SAT);
  localparam logic [DUTY_W:0]   PERIOD_X  = (DUTY_W+1)'(PWM_PERIOD);
  localparam logic [DUTY_W-1:0] PERIOD_D  = DUTY_W'(PWM_PERIOD);
  localparam logic [DUTY_W-1:0] PCNT_LAST = DUTY_W'(PWM_PERIOD - 1);
  localparam logic [DUTY_W-1:0] INIT_D    = DUTY_W'(DUTY_INIT);
  localparam logic [RAMP_W-1:0] RAMP_LOAD = RAMP_W'(RAMP_DIV - 1);
  localparam logic [PRE_W-1:0]  PRE_LOAD  = PRE_W'(PRESCALE - 1);
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYC - 1);
  localparam logic [2:0]        CH_LAST   = 3'(CHANNELS - 1);

  typedef enum logic [1:0] {StOff, StRun, StBrake} chanState_t;

  logic              frameOk;
  logic              accept;
  logic [7:0]        cmd;
  logic              cmdPwr, cmdUp, cmdDn, cmdDir, cmdCh;
  logic [RAMP_W-1:0] rampCnt;
  logic              rampTick;
  logic [PRE_W-1:0]  preCnt;
  logic              pwmStep;
  logic [DUTY_W-1:0] pcnt;
  logic              pcntWrap;
  logic [2:0]        selChan;

  assign cmd = CodeIn[23:16];

`ifdef ADDR_FILTER_EN
  assign frameOk = (CodeIn[31:24] == ~CodeIn[23:16]) &&
                   (CodeIn[15:8] == ~CodeIn[7:0]) &&
                   (CodeIn[7:0] == ADDR_VAL);
`else
  logic unusedAddr;
  assign unusedAddr = ^{CodeIn[15:0], ADDR_VAL};
  assign frameOk    = (CodeIn[31:24] == ~CodeIn[23:16]);
`endif

  assign accept = CodeValid && frameOk;
  assign cmdPwr = accept && (cmd == KEY_PWR);
  assign cmdUp  = accept && (cmd == KEY_UP);
  assign cmdDn  = accept && (cmd == KEY_DN);
  assign cmdDir = accept && (cmd == KEY_DIR);
  assign cmdCh  = accept && (cmd == KEY_CH);

  assign rampTick = (rampCnt == '0);
  assign pwmStep  = (preCnt == '0);
  assign pcntWrap = pwmStep && (pcnt == PCNT_LAST);

  // Channel selection and the one-cycle rejected-frame pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      selChan <= '0;
      CodeErr <= 1'b0;
    end else begin
      CodeErr <= CodeValid && !frameOk;
      if (cmdCh) selChan <= (selChan == CH_LAST) ? 3'd0 : selChan + 3'd1;
    end
  end

  assign SelChan = selChan;

  // Global ramp-tick divider and PWM prescaler/period counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rampCnt <= RAMP_LOAD;
      preCnt  <= PRE_LOAD;
      pcnt    <= '0;
    end else begin
      rampCnt <= rampTick ? RAMP_LOAD : rampCnt - 1'b1;
      preCnt  <= pwmStep ? PRE_LOAD : preCnt - 1'b1;
      if (pwmStep) pcnt <= (pcnt == PCNT_LAST) ? '0 : pcnt + 1'b1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : gChan
    chanState_t        st, stN;
    logic              dir, dirN;
    logic [DUTY_W-1:0] tgt, tgtN;
    logic [DUTY_W-1:0] app, appN;
    logic [DUTY_W-1:0] sh, shN;
    logic [DEAD_W-1:0] deadCnt, deadN;
    logic [1:0]        drive, driveN;
    logic [DUTY_W:0]   upSum;
    logic              hit;
    logic              forceOff;
    logic              pwm;

    assign hit   = (selChan == 3'(i));
    assign upSum = {1'b0, tgt} + STEP_X;
    assign pwm   = (pcnt < sh);

    // Command handling first, then ramp/dead-time/shadow updates on the result.
    always_comb begin
      stN      = st;
      dirN     = dir;
      tgtN     = tgt;
      appN     = app;
      shN      = sh;
      deadN    = DEAD_LOAD;
      forceOff = 1'b0;
      driveN   = 2'b00;
      if (hit) begin
        if (cmdUp) tgtN = (upSum > PERIOD_X) ? PERIOD_D : upSum[DUTY_W-1:0];
        if (cmdDn) tgtN = ({1'b0, tgt} < STEP_X) ? '0 : tgt - STEP_X[DUTY_W-1:0];
        if (cmdPwr) begin
          if (st == StOff) begin
            stN = StRun;
          end else begin
            stN      = StOff;
            forceOff = 1'b1;
          end
        end
        if (cmdDir) begin
          if (st == StOff)      dirN = ~dir;
          else if (st == StRun) stN  = StBrake;
        end
      end
      case (stN)
        StRun: begin
          if (rampTick) begin
            if (app < tgtN)      appN = app + 1'b1;
            else if (app > tgtN) appN = app - 1'b1;
          end
        end
        StBrake: begin
          if (rampTick && (app != '0)) appN = app - 1'b1;
        end
        default: appN = '0;
      endcase
      // Dead time only counts once the pair is provably silent.
      if ((stN == StBrake) && (app == '0) && (sh == '0)) begin
        if (deadCnt == '0) begin
          dirN = ~dir;
          stN  = StRun;
        end else begin
          deadN = deadCnt - 1'b1;
        end
      end
      if (pcntWrap) shN = app;
      if (forceOff) shN = '0;
      if (!forceOff) driveN = {pwm & dir, pwm & ~dir};
    end

    // Per-channel state registers, including the registered pair outputs.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        st      <= StOff;
        dir     <= 1'b0;
        tgt     <= INIT_D;
        app     <= '0;
        sh      <= '0;
        deadCnt <= DEAD_LOAD;
        drive   <= 2'b00;
      end else begin
        st      <= stN;
        dir     <= dirN;
        tgt     <= tgtN;
        app     <= appN;
        sh      <= shN;
        deadCnt <= deadN;
        drive   <= driveN;
      end
    end

    assign DriveOut[2*i +: 2] = drive;
    assign ChanOn[i]          = (st != StOff);
  end

endmodule

// File: tb/tb_nec_motor_ctrl.sv
// Directed bench for nec_motor_ctrl with a queue scoreboard of expected values.
module tb_nec_motor_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CodeValid = 1'b0;
  logic [31:0] CodeIn = '0;
  logic [3:0]  DriveOut;
  logic [2:0]  SelChan;
  logic [1:0]  ChanOn;
  logic        CodeErr;

  int compared = 0;
  int mismatched = 0;
  int overlap = 0;

  string       tagQ[$];
  logic [31:0] valQ[$];

  nec_motor_ctrl #(
    .CHANNELS(2), .DUTY_W(7), .PWM_PERIOD(10), .PRESCALE(1), .DUTY_STEP(3),
    .DUTY_INIT(6), .RAMP_DIV(4), .DEAD_CYC(8),
    .KEY_PWR(8'h45), .KEY_UP(8'h46), .KEY_DN(8'h15), .KEY_DIR(8'h44),
    .KEY_CH(8'h40), .ADDR_VAL(8'h00)
  ) dut (
    .CLK(CLK), .RST(RST), .CodeValid(CodeValid), .CodeIn(CodeIn),
    .DriveOut(DriveOut), .SelChan(SelChan), .ChanOn(ChanOn), .CodeErr(CodeErr)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (!RST && ((DriveOut[0] & DriveOut[1]) || (DriveOut[2] & DriveOut[3])))
      overlap++;
  end

  function automatic logic [31:0] frame(input logic [7:0] c, input logic [7:0] a);
    return {~c, c, ~a, a};
  endfunction

  task automatic pushExp(input string tag, input logic [31:0] v);
    tagQ.push_back(tag);
    valQ.push_back(v);
  endtask

  task automatic check(input logic [31:0] obs);
    string       tag;
    logic [31:0] expv;
    compared++;
    if (valQ.size() == 0) begin
      mismatched++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      tag  = tagQ.pop_front();
      expv = valQ.pop_front();
      assert (obs === expv) else begin
        mismatched++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
    end
  endtask

  task automatic send(input logic [31:0] code);
    CodeIn    = code;
    CodeValid = 1'b1;
    @(negedge CLK);
    CodeValid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge CLK);
  endtask

  task automatic window(output int f0, output int r0, output int f1, output int r1);
    f0 = 0; r0 = 0; f1 = 0; r1 = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      f0 += int'(DriveOut[0]);
      r0 += int'(DriveOut[1]);
      f1 += int'(DriveOut[2]);
      r1 += int'(DriveOut[3]);
    end
  endtask

  task automatic waitBit(input int b, input string tag);
    logic ok = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(negedge CLK);
      if (DriveOut[b]) ok = 1'b1;
    end
    pushExp(tag, 1);
    check(ok);
  endtask

  initial begin
    int f0, r0, f1, r1;
    int lowRun, maxLow;

    // Reset state
    idle(2);
    pushExp("rst_drive", 0);  check(DriveOut);
    pushExp("rst_sel", 0);    check(SelChan);
    pushExp("rst_on", 0);     check(ChanOn);
    pushExp("rst_err", 0);    check(CodeErr);
    RST = 1'b0;
    idle(2);

    // Power on channel 0 and ramp to the initial target
    send(frame(8'h45, 8'h00));
    pushExp("pwr_on_ch0", 2'b01); check(ChanOn);
    idle(50);
    window(f0, r0, f1, r1);
    pushExp("duty6_fwd", 6); check(f0);
    pushExp("duty6_rev", 0); check(r0);
    pushExp("ch1_idle", 0);  check(f1 + r1);

    // UP saturates at the period
    repeat (3) begin send(frame(8'h46, 8'h00)); idle(1); end
    idle(40);
    window(f0, r0, f1, r1);
    pushExp("up_sat", 10); check(f0);

    // DN saturates at zero without wrapping
    repeat (5) begin send(frame(8'h15, 8'h00)); idle(1); end
    idle(60);
    window(f0, r0, f1, r1);
    pushExp("dn_sat", 0); check(f0);

    repeat (2) begin send(frame(8'h46, 8'h00)); idle(1); end
    idle(50);
    window(f0, r0, f1, r1);
    pushExp("up_back6", 6); check(f0);

    // Corrupted frame: error pulse, no action
    send({8'h00, 8'h46, 8'hFF, 8'h00});
    pushExp("bad_err_pulse", 1); check(CodeErr);
    idle(1);
    pushExp("bad_err_clear", 0); check(CodeErr);
    idle(30);
    window(f0, r0, f1, r1);
    pushExp("bad_no_action", 6); check(f0);

    // Unknown command: silent
    send(frame(8'h12, 8'h00));
    pushExp("unk_err", 0); check(CodeErr);
    pushExp("unk_sel", 0); check(SelChan);

    // Direction reversal through brake and dead time
    send(frame(8'h44, 8'h00));
    pushExp("brake_on", 2'b01); check(ChanOn);
    lowRun = 0; maxLow = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge CLK);
      if (DriveOut[1:0] == 2'b00) lowRun++;
      else lowRun = 0;
      if (lowRun > maxLow) maxLow = lowRun;
    end
    pushExp("dead_low_run", 1); check(maxLow >= 8);
    window(f0, r0, f1, r1);
    pushExp("rev_fwd", 0); check(f0);
    pushExp("rev_rev", 6); check(r0);

    // Select channel 1 and power it on
    send(frame(8'h40, 8'h00));
    pushExp("sel_ch1", 1); check(SelChan);
    send(frame(8'h45, 8'h00));
    pushExp("ch1_on", 2'b11); check(ChanOn);
    idle(50);
    window(f0, r0, f1, r1);
    pushExp("ch1_fwd", 6);  check(f1);
    pushExp("ch1_rev", 0);  check(r1);
    pushExp("ch0_kept", 6); check(r0);

    // Power off in the middle of a brake
    send(frame(8'h44, 8'h00));
    pushExp("ch1_brake_on", 2'b11); check(ChanOn);
    waitBit(2, "wait_ch1_high");
    send(frame(8'h45, 8'h00));
    pushExp("off_pair_low", 0); check(DriveOut[3:2]);
    pushExp("off_chan", 2'b01); check(ChanOn);
    send(frame(8'h45, 8'h00));
    idle(50);
    window(f0, r0, f1, r1);
    pushExp("dir_kept_fwd", 6); check(f1);
    pushExp("dir_kept_rev", 0); check(r1);

    // Asynchronous reset mid-period
    waitBit(1, "wait_ch0_high");
    #2 RST = 1'b1;
    #1;
    pushExp("async_rst_drive", 0); check(DriveOut);
    @(negedge CLK);
    RST = 1'b0;
    idle(1);
    pushExp("post_rst_on", 0);  check(ChanOn);
    pushExp("post_rst_sel", 0); check(SelChan);
    send(frame(8'h45, 8'h00));
    idle(50);
    window(f0, r0, f1, r1);
    pushExp("post_rst_fwd", 6); check(f0);
    pushExp("post_rst_rev", 0); check(r0);

    // Address byte handling
    send(frame(8'h40, 8'h01));
`ifdef ADDR_FILTER_EN
    pushExp("addr_err", 1); check(CodeErr);
    pushExp("addr_sel", 0); check(SelChan);
`else
    pushExp("addr_err", 0); check(CodeErr);
    pushExp("addr_sel", 1); check(SelChan);
`endif

    idle(2);
    pushExp("pair_overlap", 0); check(overlap);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
